// File: rtl/mosq_pkg.sv
// Shared types and constants for the mosquito-detection front-end sequencer.
package mosq_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned CNT_W    = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRIME,
      S_CAPTURE,
      S_WAIT_RES,
      S_HOLDOFF
   } state_t;

   // Bits needed to hold 0..n-1; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mosq_decim2.sv
// 2:1 pair averager: the second sample of each pair emits (a+b)>>>1 combinationally.
module mosq_decim2
   import mosq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic [SAMPLE_W-1:0] in_data,
   input  logic                in_vld,
   output logic [SAMPLE_W-1:0] out_data,
   output logic                out_vld
);

   logic                phase;
   logic [SAMPLE_W-1:0] first;
   logic [SAMPLE_W:0]   sum;

   always_comb begin
      sum = {first[SAMPLE_W-1], first} + {in_data[SAMPLE_W-1], in_data};
   end

   assign out_data = sum[SAMPLE_W:1];
   assign out_vld  = in_vld && phase;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 1'b0;
         first <= '0;
      end else if (clr) begin
         phase <= 1'b0;
      end else if (in_vld) begin
         phase <= !phase;
         if (!phase) first <= in_data;
      end
   end

endmodule

// File: rtl/mosq_frame_ctrl.sv
// Frame sequencer: PRIME -> CAPTURE -> WAIT_RES -> HOLDOFF, one frame in flight.
// Build option MOSQ_FRAME_DECIM_EN inserts a 2:1 pair averager ahead of forwarding.
module mosq_frame_ctrl
   import mosq_pkg::*;
#(
   parameter int unsigned FRAME_LEN = 64,
   parameter int unsigned PRIME_LEN = 16,
   parameter int unsigned TIMEOUT   = 4096,
   parameter int unsigned HOLDOFF   = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_vld,
   input  logic                res_vld,
   output logic [SAMPLE_W-1:0] pipe_din,
   output logic                pipe_in_en,
   output logic                pipe_frame,
   output logic                busy,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic [CNT_W-1:0]    drop_cnt,
   output logic                timeout_err
);

   localparam int unsigned SCNT_W = cnt_width(FRAME_LEN);
   localparam int unsigned TCNT_W = cnt_width(TIMEOUT);
   localparam int unsigned HCNT_W = cnt_width(HOLDOFF);

   state_t              state, state_nxt;
   logic [SCNT_W-1:0]   sample_cnt;
   logic [TCNT_W-1:0]   tmo_cnt;
   logic [HCNT_W-1:0]   hold_cnt;
   logic                enable_q;
   logic                active;
   logic                fwd_vld;
   logic [SAMPLE_W-1:0] fwd_data;
   logic                last_prime, decided, timed_out;

   assign active = (state == S_PRIME) || (state == S_CAPTURE);
   assign busy   = (state != S_IDLE);

`ifdef MOSQ_FRAME_DECIM_EN
   // Pairing is held cleared outside PRIME/CAPTURE, so every PRIME entry starts a fresh pair.
   mosq_decim2 u_decim (
      .clk      (clk),
      .rst      (rst),
      .clr      (!active),
      .in_data  (adc_data),
      .in_vld   (adc_vld && active),
      .out_data (fwd_data),
      .out_vld  (fwd_vld)
   );
`else
   assign fwd_data = adc_data;
   assign fwd_vld  = adc_vld && active;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      last_prime = 1'b0;
      decided    = 1'b0;
      timed_out  = 1'b0;
      case (state)
         S_IDLE:
            if (enable) state_nxt = S_PRIME;
         S_PRIME:
            if (fwd_vld && sample_cnt == SCNT_W'(PRIME_LEN - 1)) begin
               last_prime = 1'b1;
               state_nxt  = S_CAPTURE;
            end
         S_CAPTURE:
            if (fwd_vld && sample_cnt == SCNT_W'(FRAME_LEN - 1)) state_nxt = S_WAIT_RES;
         S_WAIT_RES:
            // A decision arriving in the expiry cycle takes precedence over the timeout.
            if (res_vld) begin
               decided   = 1'b1;
               state_nxt = S_HOLDOFF;
            end else if (tmo_cnt == TCNT_W'(TIMEOUT - 1)) begin
               timed_out = 1'b1;
               state_nxt = S_HOLDOFF;
            end
         S_HOLDOFF:
            if (hold_cnt == HCNT_W'(HOLDOFF - 1)) state_nxt = enable ? S_PRIME : S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_din    <= '0;
         pipe_in_en  <= 1'b0;
         pipe_frame  <= 1'b0;
         sample_cnt  <= '0;
         tmo_cnt     <= '0;
         hold_cnt    <= '0;
         frame_cnt   <= '0;
         drop_cnt    <= '0;
         timeout_err <= 1'b0;
         enable_q    <= 1'b0;
      end else begin
         enable_q   <= enable;
         pipe_din   <= fwd_data;
         pipe_in_en <= fwd_vld;
         pipe_frame <= (state == S_CAPTURE);

         if (!active || last_prime) sample_cnt <= '0;
         else if (fwd_vld)          sample_cnt <= sample_cnt + SCNT_W'(1);

         if (state != S_WAIT_RES) tmo_cnt <= '0;
         else                     tmo_cnt <= tmo_cnt + TCNT_W'(1);

         if (state != S_HOLDOFF) hold_cnt <= '0;
         else                    hold_cnt <= hold_cnt + HCNT_W'(1);

         if (decided) frame_cnt <= frame_cnt + CNT_W'(1);

         if (adc_vld && !active && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);

         if (timed_out)                timeout_err <= 1'b1;
         else if (enable && !enable_q) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mosq_frame_ctrl.sv
// Randomized bench for mosq_frame_ctrl against a phase/countdown reference model.
module tb_mosq_frame_ctrl;

   localparam int unsigned FRAME_LEN = 64;
   localparam int unsigned PRIME_LEN = 16;
   localparam int unsigned TIMEOUT   = 4096;
   localparam int unsigned HOLDOFF   = 8;
`ifdef MOSQ_FRAME_DECIM_EN
   localparam int DEC = 1;
`else
   localparam int DEC = 0;
`endif

   localparam int PH_IDLE = 0, PH_PRIME = 1, PH_CAP = 2, PH_WAIT = 3, PH_HOLD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] adc_data = '0;
   logic        adc_vld = 1'b0;
   logic        res_vld = 1'b0;
   logic [15:0] pipe_din;
   logic        pipe_in_en;
   logic        pipe_frame;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;
   logic        timeout_err;

   mosq_frame_ctrl #(
      .FRAME_LEN (FRAME_LEN),
      .PRIME_LEN (PRIME_LEN),
      .TIMEOUT   (TIMEOUT),
      .HOLDOFF   (HOLDOFF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .adc_data    (adc_data),
      .adc_vld     (adc_vld),
      .res_vld     (res_vld),
      .pipe_din    (pipe_din),
      .pipe_in_en  (pipe_in_en),
      .pipe_frame  (pipe_frame),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .drop_cnt    (drop_cnt),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: phase plus "samples left" / "cycles waited" countdowns.
   int          ph, left, age, frames, drops;
   bit          terr, prev_en, m_en, m_frame, half_ok;
   logic [15:0] m_din;
   int          half;
   int          cyc, tally_pre, tally_frm;

   function automatic void model_reset();
      ph = PH_IDLE; left = 0; age = 0; frames = 0; drops = 0;
      terr = 0; prev_en = 0; m_en = 0; m_frame = 0; m_din = '0; half_ok = 0; half = 0;
   endfunction

   function automatic void model_step();
      bit act;
      bit fwd;
      int fd;
      act = (ph == PH_PRIME) || (ph == PH_CAP);
      fwd = 0;
      fd  = $signed(adc_data);
      if (act && adc_vld) begin
`ifdef MOSQ_FRAME_DECIM_EN
         if (half_ok) begin
            fwd = 1;
            fd = (half + $signed(adc_data)) >>> 1;
            half_ok = 0;
         end else begin
            half = $signed(adc_data);
            half_ok = 1;
         end
`else
         fwd = 1;
`endif
      end
      m_en = fwd;
      if (fwd) m_din = 16'(fd);
      m_frame = (ph == PH_CAP);
      if (adc_vld && !act && drops < 65535) drops++;
      if (enable && !prev_en) terr = 0;
      prev_en = enable;
      case (ph)
         PH_IDLE: if (enable) begin ph = PH_PRIME; left = PRIME_LEN; half_ok = 0; end
         PH_PRIME: if (fwd) begin
            left--;
            if (left == 0) begin ph = PH_CAP; left = FRAME_LEN; end
         end
         PH_CAP: if (fwd) begin
            left--;
            if (left == 0) begin ph = PH_WAIT; age = 0; end
         end
         PH_WAIT:
            if (res_vld) begin frames = (frames + 1) % 65536; ph = PH_HOLD; left = HOLDOFF; end
            else if (age == TIMEOUT - 1) begin terr = 1; ph = PH_HOLD; left = HOLDOFF; end
            else age++;
         default: begin
            left--;
            if (left == 0) begin
               if (enable) begin ph = PH_PRIME; left = PRIME_LEN; half_ok = 0; end
               else ph = PH_IDLE;
            end
         end
      endcase
   endfunction

   task automatic step(input logic en, input logic vld, input logic res, input logic [15:0] data);
      enable = en; adc_vld = vld; res_vld = res; adc_data = data;
      model_step();
      @(posedge clk); #1;
      cyc++;
      check("pipe_in_en", pipe_in_en, m_en);
      if (m_en) check("pipe_din", pipe_din, m_din);
      check("pipe_frame", pipe_frame, m_frame);
      check("busy", busy, ph != PH_IDLE);
      check("frame_cnt", frame_cnt, frames);
      check("drop_cnt", drop_cnt, drops);
      check("timeout_err", timeout_err, terr);
      if (pipe_in_en) begin
         if (pipe_frame) tally_frm++;
         else            tally_pre++;
      end
   endtask

   task automatic async_reset();
      #2; rst = 1'b1; #1;
      check("rst_pipe_din", pipe_din, 0);
      check("rst_pipe_in_en", pipe_in_en, 0);
      check("rst_pipe_frame", pipe_frame, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_timeout_err", timeout_err, 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0; enable = 1'b0; adc_vld = 1'b0; res_vld = 1'b0;
   endtask

   task automatic run_to(input int target, input logic en, input int period, input int budget);
      int n;
      n = 0;
      while (ph != target && n < budget) begin
         step(en, (cyc % period) == 0, 1'b0, 16'($urandom));
         n++;
      end
      if (ph != target) check("reach_phase", ph, target);
   endtask

   initial begin
      int base, first, w, f0, n;
      model_reset();
      cyc = 0; tally_pre = 0; tally_frm = 0;
      async_reset();

      // Basic frame with a strobe every 4 cycles.
      run_to(PH_WAIT, 1'b1, 4, 2000);
      check("prime_fwd", tally_pre, PRIME_LEN);
      check("frame_fwd", tally_frm, FRAME_LEN);
      base = drops;
      for (int i = 0; i < 40; i++) step(1'b1, (i % 4) == 0, 1'b0, 16'($urandom));
      check("wait_drops", drop_cnt, base + 10);
      check("wait_no_fwd", tally_pre + tally_frm, PRIME_LEN + FRAME_LEN);
      step(1'b1, 1'b0, 1'b1, 16'($urandom));
      check("first_decision", frame_cnt, 1);
      first = 0;
      for (int i = 1; i <= 30 && first == 0; i++) begin
         step(1'b1, 1'b1, 1'b0, 16'($urandom));
         if (pipe_in_en) first = i;
      end
      check("holdoff_gap", first, HOLDOFF + 1 + DEC);

      // Timeout with res_vld withheld.
      f0 = frames;
      run_to(PH_WAIT, 1'b1, 2, 2000);
      w = 0;
      while (ph == PH_WAIT && w < int'(TIMEOUT) + 10) begin
         step(1'b1, 1'b0, 1'b0, 16'($urandom));
         w++;
      end
      check("timeout_cycles", w, TIMEOUT);
      check("timeout_set", timeout_err, 1);
      check("timeout_frames", frame_cnt, f0);
      run_to(PH_PRIME, 1'b1, 1, 50);
      step(1'b0, 1'b1, 1'b0, 16'($urandom));
      step(1'b1, 1'b1, 1'b0, 16'($urandom));
      check("enable_edge_clears", timeout_err, 0);

      // Decision in the exact expiry cycle.
      run_to(PH_WAIT, 1'b1, 1, 2000);
      f0 = frames;
      n = 0;
      while (ph == PH_WAIT && age < int'(TIMEOUT) - 1 && n < int'(TIMEOUT)) begin
         step(1'b1, 1'b0, 1'b0, 16'($urandom));
         n++;
      end
      step(1'b1, 1'b0, 1'b1, 16'($urandom));
      check("edge_res_no_err", timeout_err, 0);
      check("edge_res_count", frame_cnt, (f0 + 1) % 65536);

      // Decision strobes during CAPTURE are ignored.
      run_to(PH_CAP, 1'b1, 1, 200);
      f0 = frames;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 16'($urandom));
      check("cap_res_ignored", frame_cnt, f0);

      // Enable drops mid-CAPTURE: frame completes, then IDLE after HOLDOFF.
      run_to(PH_WAIT, 1'b0, 1, 500);
      check("frame_completes", busy, 1);
      step(1'b0, 1'b0, 1'b1, 16'($urandom));
      for (int i = 1; i < int'(HOLDOFF); i++) step(1'b0, 1'b0, 1'b0, 16'($urandom));
      check("busy_in_holdoff", busy, 1);
      step(1'b0, 1'b0, 1'b0, 16'($urandom));
      check("idle_after_holdoff", busy, 0);

      // Async reset at CAPTURE sample 30.
      run_to(PH_CAP, 1'b1, 1, 200);
      n = 0;
      while (ph == PH_CAP && int'(FRAME_LEN) - left < 30 && n < 200) begin
         step(1'b1, 1'b1, 1'b0, 16'($urandom));
         n++;
      end
      check("cap_sample_30", FRAME_LEN - left, 30);
      async_reset();

`ifdef MOSQ_FRAME_DECIM_EN
      step(1'b1, 1'b0, 1'b0, 16'h0000);
      step(1'b1, 1'b1, 1'b0, 16'd100);
      step(1'b1, 1'b1, 1'b0, 16'd103);
      check("decim_pos_en", pipe_in_en, 1);
      check("decim_pos", pipe_din, 101);
      step(1'b1, 1'b1, 1'b0, 16'hFFFD);
      step(1'b1, 1'b1, 1'b0, 16'hFFFC);
      check("decim_neg", pipe_din, 16'hFFFC);
      async_reset();
      step(1'b1, 1'b0, 1'b0, 16'($urandom));
      tally_pre = 0; tally_frm = 0;
      for (int i = 0; i < 160; i++) step(1'b1, 1'b1, 1'b0, 16'($urandom));
      check("decim_fwd_count", tally_pre + tally_frm, 80);
`endif

      // Random soak.
      for (int i = 0; i < 3000; i++)
         step(($urandom % 16) != 0, $urandom % 2 == 1, ($urandom % 40) == 0, 16'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
